// File: rtl/clint_vec.sv
// Core-local interrupt controller: arbitrates sync traps, enabled irq lines and MRET,
// sequences the mepc/mstatus/mcause writes and issues the redirect with a one-hot claim.
module clint_vec #(
   parameter int unsigned CPU_WIDTH      = 32,
   parameter int unsigned NUM_IRQ        = 8,
   parameter int unsigned CSR_ADDR_WIDTH = 12,
   parameter int unsigned IRQ_CAUSE_BASE = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_IRQ-1:0]        irq_i,
   input  logic [NUM_IRQ-1:0]        irq_en_i,
   input  logic                      wb_valid_i,
   input  logic [CPU_WIDTH-1:0]      wb_inst_i,
   input  logic [CPU_WIDTH-1:0]      wb_inst_addr_i,
   input  logic [CPU_WIDTH-1:0]      resume_addr_i,
   input  logic [CPU_WIDTH-1:0]      csr_mtvec,
   input  logic [CPU_WIDTH-1:0]      csr_mepc,
   input  logic [CPU_WIDTH-1:0]      csr_mstatus,
   output logic                      we_o,
   output logic [CSR_ADDR_WIDTH-1:0] waddr_o,
   output logic [CPU_WIDTH-1:0]      data_o,
   output logic                      hold_flag_o,
   output logic                      int_assert_o,
   output logic [CPU_WIDTH-1:0]      int_addr_o,
   output logic [NUM_IRQ-1:0]        irq_ack_o
);

   localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS = CSR_ADDR_WIDTH'(12'h300);
   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC    = CSR_ADDR_WIDTH'(12'h341);
   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE  = CSR_ADDR_WIDTH'(12'h342);

   localparam logic [CPU_WIDTH-1:0] INST_ECALL  = CPU_WIDTH'(32'h0000_0073);
   localparam logic [CPU_WIDTH-1:0] INST_EBREAK = CPU_WIDTH'(32'h0010_0073);
   localparam logic [CPU_WIDTH-1:0] INST_MRET   = CPU_WIDTH'(32'h3020_0073);

   typedef enum logic [2:0] {
      S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_ASSERT, S_MRET
   } state_e;

   state_e               state_q, state_d;
   logic [CPU_WIDTH-1:0] epc_q, epc_d;
   logic [CPU_WIDTH-1:0] cause_q, cause_d;
   logic [IDX_W-1:0]     win_q, win_d;
   logic                 async_q, async_d;
   logic                 mret_q, mret_d;

   logic [NUM_IRQ-1:0]   pend;
   logic [IDX_W-1:0]     win_idx;
   logic                 sync_ev, async_ev, mret_ev;

   // Event detection and lowest-index winner among enabled pending lines
   always_comb begin
      pend     = irq_i & irq_en_i;
      sync_ev  = wb_valid_i && ((wb_inst_i == INST_ECALL) || (wb_inst_i == INST_EBREAK));
      async_ev = (|pend) && csr_mstatus[3];
      mret_ev  = wb_valid_i && (wb_inst_i == INST_MRET);
      win_idx  = '0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (pend[i]) win_idx = IDX_W'(i);
      end
   end

   // Next-state and latch capture; events are only accepted in IDLE
   always_comb begin
      state_d = state_q;
      epc_d   = epc_q;
      cause_d = cause_q;
      win_d   = win_q;
      async_d = async_q;
      mret_d  = mret_q;
      case (state_q)
         S_IDLE: begin
            if (sync_ev) begin
               state_d = S_MEPC;
               epc_d   = wb_inst_addr_i;
               cause_d = (wb_inst_i == INST_ECALL) ? CPU_WIDTH'(11) : CPU_WIDTH'(3);
               async_d = 1'b0;
               mret_d  = 1'b0;
            end else if (async_ev) begin
               state_d = S_MEPC;
               epc_d   = resume_addr_i;
               cause_d = {1'b1, (CPU_WIDTH-1)'(IRQ_CAUSE_BASE + 32'(win_idx))};
               win_d   = win_idx;
               async_d = 1'b1;
               mret_d  = 1'b0;
            end else if (mret_ev) begin
               state_d = S_MRET;
               async_d = 1'b0;
               mret_d  = 1'b1;
            end
         end
         S_MEPC:    state_d = S_MSTATUS;
         S_MSTATUS: state_d = S_MCAUSE;
         S_MCAUSE:  state_d = S_ASSERT;
         S_MRET:    state_d = S_ASSERT;
         S_ASSERT:  state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         epc_q   <= '0;
         cause_q <= '0;
         win_q   <= '0;
         async_q <= 1'b0;
         mret_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
         win_q   <= win_d;
         async_q <= async_d;
         mret_q  <= mret_d;
      end
   end

   // Moore output decode from the state register and latched trap context
   always_comb begin
      we_o         = 1'b0;
      waddr_o      = '0;
      data_o       = '0;
      int_assert_o = 1'b0;
      int_addr_o   = '0;
      irq_ack_o    = '0;
      case (state_q)
         S_MEPC: begin
            we_o    = 1'b1;
            waddr_o = CSR_MEPC;
            data_o  = epc_q;
         end
         S_MSTATUS: begin
            we_o      = 1'b1;
            waddr_o   = CSR_MSTATUS;
            data_o    = csr_mstatus;
            data_o[7] = csr_mstatus[3];
            data_o[3] = 1'b0;
         end
         S_MCAUSE: begin
            we_o    = 1'b1;
            waddr_o = CSR_MCAUSE;
            data_o  = cause_q;
         end
         S_MRET: begin
            we_o      = 1'b1;
            waddr_o   = CSR_MSTATUS;
            data_o    = csr_mstatus;
            data_o[3] = csr_mstatus[7];
            data_o[7] = 1'b1;
         end
         S_ASSERT: begin
            int_assert_o = 1'b1;
            if (mret_q) begin
               int_addr_o = csr_mepc;
            end else begin
               int_addr_o = {csr_mtvec[CPU_WIDTH-1:2], 2'b00};
               if ((csr_mtvec[1:0] == 2'b01) && cause_q[CPU_WIDTH-1])
                  int_addr_o = int_addr_o + {cause_q[CPU_WIDTH-3:0], 2'b00};
               for (int unsigned i = 0; i < NUM_IRQ; i++)
                  irq_ack_o[i] = async_q && (win_q == IDX_W'(i));
            end
         end
         default: ;
      endcase
   end

   assign hold_flag_o = (state_q != S_IDLE) || (state_q == S_IDLE && (sync_ev || async_ev || mret_ev));

endmodule

// File: tb/tb_clint_vec.sv
// Self-checking bench for clint_vec: directed test-plan scenarios plus randomized
// events checked against a per-cycle expectation list built from the priority rules.
module tb_clint_vec;

   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;

   typedef struct packed {
      logic        we;
      logic [11:0] waddr;
      logic [31:0] data;
      logic        ia;
      logic [31:0] iaddr;
      logic [7:0]  ack;
      logic        hold;
   } row_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  irq_i, irq_en_i;
   logic        wb_valid_i;
   logic [31:0] wb_inst_i, wb_inst_addr_i, resume_addr_i;
   logic [31:0] csr_mtvec, csr_mepc, csr_mstatus;
   logic        we_o, hold_flag_o, int_assert_o;
   logic [11:0] waddr_o;
   logic [31:0] data_o, int_addr_o;
   logic [7:0]  irq_ack_o;

   int n_checks = 0;
   int n_errors = 0;
   row_t exp_q[$];

   clint_vec dut (
      .clk(clk), .rst(rst), .irq_i(irq_i), .irq_en_i(irq_en_i),
      .wb_valid_i(wb_valid_i), .wb_inst_i(wb_inst_i), .wb_inst_addr_i(wb_inst_addr_i),
      .resume_addr_i(resume_addr_i), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
      .csr_mstatus(csr_mstatus), .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
      .hold_flag_o(hold_flag_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o),
      .irq_ack_o(irq_ack_o)
   );

   always #5 clk = ~clk;

   function automatic row_t mk(input logic we, input logic [11:0] wa, input logic [31:0] d,
                               input logic ia, input logic [31:0] a, input logic [7:0] ack,
                               input logic hold);
      row_t r;
      r.we = we; r.waddr = wa; r.data = d; r.ia = ia; r.iaddr = a; r.ack = ack; r.hold = hold;
      return r;
   endfunction

   function automatic row_t observe();
      return mk(we_o, waddr_o, data_o, int_assert_o, int_addr_o, irq_ack_o, hold_flag_o);
   endfunction

   // Reference: derive the whole cycle-by-cycle response from the current inputs
   task automatic build_expected();
      logic        is_sync, is_async, is_mret;
      logic [31:0] epc, cause, ms_trap, ms_ret, target;
      logic [7:0]  ack;
      int          win;
      exp_q.delete();
      is_sync  = wb_valid_i && (wb_inst_i == ECALL || wb_inst_i == EBREAK);
      is_async = ((irq_i & irq_en_i) != 0) && csr_mstatus[3];
      is_mret  = wb_valid_i && (wb_inst_i == MRET);
      win = -1;
      for (int i = 0; i < 8; i++) if (win < 0 && irq_i[i] && irq_en_i[i]) win = i;
      ack = 8'h00;
      if (is_sync) begin
         epc   = wb_inst_addr_i;
         cause = (wb_inst_i == ECALL) ? 32'd11 : 32'd3;
      end else begin
         epc   = resume_addr_i;
         cause = 32'h8000_0000 + 32'd16 + 32'(win);
         if (is_async) ack = 8'(1 << win);
      end
      ms_trap = (csr_mstatus & ~32'h88) | (csr_mstatus[3] ? 32'h80 : 32'h0);
      ms_ret  = (csr_mstatus & ~32'h08) | 32'h80 | (csr_mstatus[7] ? 32'h8 : 32'h0);
      target  = csr_mtvec & ~32'h3;
      if (csr_mtvec[1:0] == 2'b01 && cause[31]) target = target + 4 * (cause & 32'h7FFF_FFFF);
      if (is_sync || is_async) begin
         exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
         exp_q.push_back(mk(1, 12'h341, epc, 0, 0, 0, 1));
         exp_q.push_back(mk(1, 12'h300, ms_trap, 0, 0, 0, 1));
         exp_q.push_back(mk(1, 12'h342, cause, 0, 0, 0, 1));
         exp_q.push_back(mk(0, 0, 0, 1, target, ack, 1));
         exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      end else if (is_mret) begin
         exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
         exp_q.push_back(mk(1, 12'h300, ms_ret, 0, 0, 0, 1));
         exp_q.push_back(mk(0, 0, 0, 1, csr_mepc, 0, 1));
         exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      end else begin
         exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      end
   endtask

   // Step through expected rows; irq lines wander mid-sequence, last row is quiet
   task automatic run_rows(input row_t exp[$], input string name);
      row_t obs;
      for (int k = 0; k < exp.size(); k++) begin
         if (k > 0) begin
            @(negedge clk);
            wb_valid_i = 1'b0;
            irq_i = (k == exp.size() - 1) ? 8'h00 : 8'($urandom);
         end
         #1;
         obs = observe();
         n_checks++;
         if (obs !== exp[k]) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, k, obs, exp[k]);
         end
      end
   endtask

   task automatic quiet();
      irq_i = 8'h00; irq_en_i = 8'h00; wb_valid_i = 1'b0; wb_inst_i = 32'h13;
      wb_inst_addr_i = 32'h0; resume_addr_i = 32'h0;
   endtask

   task automatic test_reset();
      row_t obs;
      rst = 1'b1;
      quiet();
      csr_mtvec = 32'h0; csr_mepc = 32'h0; csr_mstatus = 32'h8;
      repeat (2) @(negedge clk);
      #1;
      obs = observe();
      n_checks++;
      if (obs !== mk(0, 0, 0, 0, 0, 0, 0)) begin
         n_errors++;
         $display("FAIL reset: got %h expected all-zero", obs);
      end
      rst = 1'b0;
   endtask

   task automatic test_ecall();
      row_t e[$];
      @(negedge clk);
      quiet();
      csr_mtvec = 32'h200; csr_mstatus = 32'h8;
      wb_valid_i = 1'b1; wb_inst_i = ECALL; wb_inst_addr_i = 32'h100;
      e.push_back(mk(0, 0, 0, 0, 0, 0, 1));
      e.push_back(mk(1, 12'h341, 32'h100, 0, 0, 0, 1));
      e.push_back(mk(1, 12'h300, 32'h80, 0, 0, 0, 1));
      e.push_back(mk(1, 12'h342, 32'd11, 0, 0, 0, 1));
      e.push_back(mk(0, 0, 0, 1, 32'h200, 0, 1));
      e.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      run_rows(e, "ecall");
   endtask

   task automatic test_vectored();
      row_t e[$];
      @(negedge clk);
      quiet();
      irq_i = 8'b0110; irq_en_i = 8'hFF; csr_mstatus = 32'h8;
      csr_mtvec = 32'h1001; resume_addr_i = 32'h340;
      e.push_back(mk(0, 0, 0, 0, 0, 0, 1));
      e.push_back(mk(1, 12'h341, 32'h340, 0, 0, 0, 1));
      e.push_back(mk(1, 12'h300, 32'h80, 0, 0, 0, 1));
      e.push_back(mk(1, 12'h342, 32'h8000_0011, 0, 0, 0, 1));
      e.push_back(mk(0, 0, 0, 1, 32'h1044, 8'b0010, 1));
      e.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      run_rows(e, "vectored");
   endtask

   task automatic test_masking();
      row_t e[$];
      e.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         quiet();
         irq_i = 8'h01; irq_en_i = 8'h00; csr_mstatus = 32'h8;
         run_rows(e, "mask_en");
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         quiet();
         irq_i = 8'h01; irq_en_i = 8'hFF; csr_mstatus = 32'h0;
         run_rows(e, "mask_mie");
      end
   endtask

   task automatic test_simultaneous();
      row_t e[$];
      row_t obs;
      @(negedge clk);
      quiet();
      csr_mtvec = 32'h200; csr_mstatus = 32'h8;
      wb_valid_i = 1'b1; wb_inst_i = EBREAK; wb_inst_addr_i = 32'h180;
      irq_i = 8'h01; irq_en_i = 8'hFF; resume_addr_i = 32'h500;
      e.push_back(mk(0, 0, 0, 0, 0, 0, 1));
      e.push_back(mk(1, 12'h341, 32'h180, 0, 0, 0, 1));
      e.push_back(mk(1, 12'h300, 32'h80, 0, 0, 0, 1));
      e.push_back(mk(1, 12'h342, 32'd3, 0, 0, 0, 1));
      e.push_back(mk(0, 0, 0, 1, 32'h200, 0, 1));
      e.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      run_rows(e, "simul");
      // MIE now cleared by the trap: the still-pending line must stay untaken
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         csr_mstatus = 32'h80; irq_i = 8'h01; irq_en_i = 8'hFF;
         #1;
         obs = observe();
         n_checks++;
         if (obs !== mk(0, 0, 0, 0, 0, 0, 0)) begin
            n_errors++;
            $display("FAIL simul_no_retake cycle %0d: got %h expected all-zero", c, obs);
         end
      end
      irq_i = 8'h00;
   endtask

   task automatic test_mret();
      row_t e[$];
      @(negedge clk);
      quiet();
      csr_mstatus = 32'h80; csr_mepc = 32'h44;
      wb_valid_i = 1'b1; wb_inst_i = MRET;
      e.push_back(mk(0, 0, 0, 0, 0, 0, 1));
      e.push_back(mk(1, 12'h300, 32'h88, 0, 0, 0, 1));
      e.push_back(mk(0, 0, 0, 1, 32'h44, 0, 1));
      e.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      run_rows(e, "mret");
   endtask

   task automatic test_reset_mid();
      row_t e[$];
      row_t obs;
      @(negedge clk);
      quiet();
      csr_mtvec = 32'h200; csr_mstatus = 32'h8;
      wb_valid_i = 1'b1; wb_inst_i = ECALL; wb_inst_addr_i = 32'h2A0;
      e.push_back(mk(0, 0, 0, 0, 0, 0, 1));
      e.push_back(mk(1, 12'h341, 32'h2A0, 0, 0, 0, 1));
      e.push_back(mk(1, 12'h300, 32'h80, 0, 0, 0, 1));
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin @(negedge clk); wb_valid_i = 1'b0; end
         #1;
         obs = observe();
         n_checks++;
         if (obs !== e[k]) begin
            n_errors++;
            $display("FAIL reset_mid pre cycle %0d: got %h expected %h", k, obs, e[k]);
         end
      end
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (c == 1) rst = 1'b0;
         #1;
         obs = observe();
         n_checks++;
         if (obs !== mk(0, 0, 0, 0, 0, 0, 0)) begin
            n_errors++;
            $display("FAIL reset_mid post cycle %0d: got %h expected all-zero", c, obs);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] insts [5];
      for (int it = 0; it < 60; it++) begin
         @(negedge clk);
         insts[0] = ECALL; insts[1] = EBREAK; insts[2] = MRET; insts[3] = 32'h13;
         insts[4] = $urandom;
         irq_i          = 8'($urandom);
         irq_en_i       = 8'($urandom);
         wb_valid_i     = 1'($urandom);
         wb_inst_i      = insts[$urandom_range(0, 4)];
         wb_inst_addr_i = $urandom;
         resume_addr_i  = $urandom;
         csr_mtvec      = $urandom;
         csr_mepc       = $urandom;
         csr_mstatus    = $urandom;
         build_expected();
         run_rows(exp_q, "random");
      end
   endtask

   initial begin
      test_reset();
      test_ecall();
      test_vectored();
      test_masking();
      test_simultaneous();
      test_mret();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/clint_vec.md
Name: clint_vec

Overview:
- Parametrised core-local interrupt controller. Successor to the single-source CLINT.
- Arbitrates NUM_IRQ level-sensitive external interrupt lines, each with its own enable, plus synchronous ECALL/EBREAK traps and MRET returns from the write-back stage.
- Sequences the mepc/mstatus/mcause CSR writes, then asserts a redirect to flow_ctrl.
- Supports direct and vectored mtvec modes and returns a one-hot acknowledge to the winning source.

Parameters:
- CPU_WIDTH, 32, data/address width.
- NUM_IRQ, 8, number of async interrupt lines (1..16).
- CSR_ADDR_WIDTH, 12, CSR address width.
- IRQ_CAUSE_BASE, 16, exception code of irq line 0; line i uses IRQ_CAUSE_BASE+i.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- irq_i  in  NUM_IRQ  level interrupt requests.
- irq_en_i  in  NUM_IRQ  per-line enable (mie image).
- wb_valid_i  in  1  write-back slot holds a retiring instruction.
- wb_inst_i  in  CPU_WIDTH  write-back instruction word.
- wb_inst_addr_i  in  CPU_WIDTH  write-back instruction address.
- resume_addr_i  in  CPU_WIDTH  address of oldest un-retired instruction (async return point).
- csr_mtvec  in  CPU_WIDTH  mtvec value.
- csr_mepc  in  CPU_WIDTH  mepc value.
- csr_mstatus  in  CPU_WIDTH  mstatus value.
- we_o  out  1  CSR write strobe.
- waddr_o  out  CSR_ADDR_WIDTH  CSR write address.
- data_o  out  CPU_WIDTH  CSR write data.
- hold_flag_o  out  1  pipeline stall.
- int_assert_o  out  1  redirect pulse.
- int_addr_o  out  CPU_WIDTH  redirect target.
- irq_ack_o  out  NUM_IRQ  one-hot claim pulse.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- States: IDLE, MEPC, MSTATUS, MCAUSE, ASSERT, MRET.
- State, latched epc, latched cause and latched winner index are registered.
- Outputs are Moore-decoded from the state register, except hold_flag_o.
- Reset (any cycle, including mid-sequence): state=IDLE, latches cleared. All outputs are 0 while in IDLE with no event.
- Event priority, evaluated in IDLE only:
  - 1) sync: wb_valid_i && inst==ECALL (cause 11) or EBREAK (cause 3); epc=wb_inst_addr_i.
  - 2) async: |(irq_i & irq_en_i) && mstatus[3]. Winner = lowest set index i. cause = {1'b1, IRQ_CAUSE_BASE+i}; epc=resume_addr_i.
  - 3) mret: wb_valid_i && inst==MRET.
  - Lower-priority events are not lost if still asserted; they are re-evaluated on the next IDLE cycle.
- Trap sequence (cycle 0 = detection in IDLE):
  - Cycle 1, MEPC: we_o=1, waddr_o=CSR_MEPC, data_o=epc.
  - Cycle 2, MSTATUS: we_o=1, waddr_o=CSR_MSTATUS, data_o = mstatus with bit7=mstatus[3] and bit3=0.
  - Cycle 3, MCAUSE: we_o=1, waddr_o=CSR_MCAUSE, data_o=cause.
  - Cycle 4, ASSERT: int_assert_o=1. int_addr_o = {mtvec[31:2],2'b00}. If mtvec[1:0]==2'b01 and cause[31]==1, add 4*cause[30:0]. irq_ack_o[i]=1 for async events only.
  - Cycle 5: IDLE.
- MRET sequence:
  - Cycle 1, MRET: we_o=1, waddr_o=CSR_MSTATUS, data_o = mstatus with bit3=mstatus[7] and bit7=1.
  - Cycle 2, ASSERT: int_assert_o=1, int_addr_o=csr_mepc, irq_ack_o=0.
  - Cycle 3: IDLE.
- hold_flag_o = (state!=IDLE) | event detected in IDLE (combinational). It is high from cycle 0 through the ASSERT cycle inclusive.
- The irq line and enables are not re-sampled during a sequence; the latched winner is used even if irq_i drops.
- Requests arriving mid-sequence are ignored until IDLE. Because of the mstatus[3]=0 write, a still-pending line is not re-taken until MRET restores MIE.
- The core drives wb_valid_i=0 in the cycle after ASSERT (flush), which prevents re-triggering on a stale write-back instruction.
- Upper CSR address bits are zero-padded; all arithmetic is modulo 2^CPU_WIDTH.

Test Plan:
- ECALL: wb_valid_i=1, ECALL at 0x100, mtvec=0x200, mstatus=0x8 -> writes mepc=0x100, mstatus=0x80, mcause=11 on cycles 1-3; cycle 4 int_assert_o=1, int_addr_o=0x200; hold_flag_o high for cycles 0-4.
- Vectored priority: irq_i=0b0110, irq_en_i=0xFF, mstatus=0x8, mtvec=0x1001, resume_addr=0x340 -> winner line 1, mcause=0x80000011, mepc=0x340; target 0x1000+4*17=0x1044; irq_ack_o=0b0010 for one cycle.
- Masking: irq_i=0x01 with irq_en_i=0x00, or with mstatus[3]=0 -> no write, hold_flag_o=0, state stays IDLE.
- Simultaneous events: EBREAK in wb and irq_i[0]=1 in the same cycle -> sync trap taken with mcause=3. The async request is not taken afterwards because MIE has been cleared.
- MRET: mstatus=0x80, mepc=0x44 -> cycle 1 writes mstatus=0x88; cycle 2 int_assert_o=1, int_addr_o=0x44.
- Reset mid-sequence: rst=1 while in MSTATUS -> next cycle IDLE, we_o=0, hold_flag_o=0, no ASSERT pulse, no mcause write.
